// File: rtl/reliability_sorter.sv
// Serial-load reliability sorter: ranks N channel metrics with an N-phase
// odd-even transposition sort and presents channel indexes in ascending order.
module reliability_sorter #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_value,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [$clog2(N):0]     sorted_indexes [N]
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned IW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   phase;
  logic [W-1:0]    key     [N];
  logic [IW-1:0]   idx     [N];
  logic [W-1:0]    key_nxt [N];
  logic [IW-1:0]   idx_nxt [N];

  assign sorted_indexes = idx;

  // One transposition phase: pairs starting at even j on even phases, odd j on odd.
  // Ties break on index so equal metrics rank the higher channel as more reliable.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      key_nxt[i] = key[i];
      idx_nxt[i] = idx[i];
    end
    for (int j = 0; j < N - 1; j++) begin
      if (j[0] == phase[0]) begin
        if ((key[j] > key[j+1]) ||
            ((key[j] == key[j+1]) && (idx[j] > idx[j+1]))) begin
          key_nxt[j]   = key[j+1];
          key_nxt[j+1] = key[j];
          idx_nxt[j]   = idx[j+1];
          idx_nxt[j+1] = idx[j];
        end
      end
    end
  end

  // Control FSM together with key/index storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      phase     <= '0;
      for (int i = 0; i < N; i++) begin
        key[i] <= '0;
        idx[i] <= IW'(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key[cnt] <= in_value;
            idx[cnt] <= IW'(cnt);
            cnt      <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              cnt      <= '0;
              phase    <= '0;
              in_ready <= 1'b0;
              state    <= SORT;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < N; i++) begin
            key[i] <= key_nxt[i];
            idx[i] <= idx_nxt[i];
          end
          phase <= phase + CW'(1);
          if (phase == CW'(N - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reliability_sorter.sv
// Scoreboard bench for reliability_sorter: directed loads with hand-derived rankings.
module tb_reliability_sorter;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int IW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_value;
  logic          out_valid;
  logic          out_ack;
  logic [IW-1:0] sorted_indexes [N];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [N*IW-1:0] exp_q [$];
  logic [W-1:0]    vals  [N];
  logic [N*IW-1:0] exp_v;

  reliability_sorter #(.N(N), .W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .out_valid      (out_valid),
    .out_ack        (out_ack),
    .sorted_indexes (sorted_indexes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: compares the presented result to the scoreboard head while valid.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_valid: out_valid=1 with no expected block");
      end else begin
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
          if (sorted_indexes[i] != exp_q[0][i*IW +: IW]) begin
            nbad++;
            if (first < 0) first = i;
          end
        end
        chk_cnt++;
        if (nbad == 0) pass_cnt++;
        else $display("FAIL result: %0d entries wrong, first [%0d] got %0d expected %0d",
                      nbad, first, sorted_indexes[first], exp_q[0][first*IW +: IW]);
        if (out_ack) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_exp(input int i, input int v);
    exp_v[i*IW +: IW] = IW'(v);
  endtask

  task automatic load(input bit gaps);
    int not_ready;
    not_ready = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      if (!in_ready) not_ready++;
      in_valid = 1'b1;
      in_value = vals[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("ready_during_load", not_ready, 0);
  endtask

  task automatic wait_done();
    int c;
    int ready_hi;
    c = 0;
    ready_hi = 0;
    while (!out_valid && c < 100) begin
      @(posedge clk);
      #1;
      c++;
      if (in_ready) ready_hi++;
    end
    check("latency", c, N);
    check("ready_low_in_sort", ready_hi, 0);
  endtask

  task automatic ack(input int hold);
    int drops;
    drops = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready) drops++;
    end
    check("done_hold", drops, 0);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check("valid_after_ack", int'(out_valid), 0);
    check("ready_after_ack", int'(in_ready), 1);
  endtask

  task automatic check_identity(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < N; i++) if (sorted_indexes[i] != IW'(i)) nbad++;
    check(name, nbad, 0);
  endtask

  task automatic reset_pulse_release();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nbad;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    out_ack  = 1'b0;

    // Reset asserted mid-cycle takes effect immediately.
    #3 rst_n = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check_identity("reset_identity");
    #10;
    reset_pulse_release();

    // Ascending metrics: identity ranking.
    for (int i = 0; i < N; i++) begin vals[i] = W'(i); set_exp(i, i); end
    exp_q.push_back(exp_v);
    load(1'b0);
    wait_done();
    ack(0);

    // Descending metrics: reversed ranking; top-K picks channels 0..15.
    for (int i = 0; i < N; i++) begin vals[i] = W'(N - 1 - i); set_exp(i, N - 1 - i); end
    exp_q.push_back(exp_v);
    load(1'b0);
    wait_done();
    nbad = 0;
    for (int i = 0; i < 16; i++) if (sorted_indexes[N-1-i] != IW'(i)) nbad++;
    check("topk_extract", nbad, 0);
    ack(0);

    // All metrics equal: ties resolved by ascending index.
    for (int i = 0; i < N; i++) begin vals[i] = 8'h55; set_exp(i, i); end
    exp_q.push_back(exp_v);
    load(1'b0);
    wait_done();
    ack(0);

    // {3,3,1,1} repeated: the 1s (indexes 2,3,6,7,...) first, then the 3s.
    for (int i = 0; i < N; i++) vals[i] = ((i % 4) < 2) ? W'(3) : W'(1);
    for (int k = 0; k < 16; k++) begin
      set_exp(k, 4 * (k / 2) + 2 + (k % 2));
      set_exp(16 + k, 4 * (k / 2) + (k % 2));
    end
    exp_q.push_back(exp_v);
    load(1'b0);
    wait_done();
    ack(0);

    // Permutation 7*i mod 32 with gaps and a long ack hold; inverse of 7 is 23.
    for (int i = 0; i < N; i++) begin vals[i] = W'((i * 7) % N); set_exp(i, (i * 23) % N); end
    exp_q.push_back(exp_v);
    load(1'b1);
    wait_done();
    ack(10);

    // Full-width values back-to-back after the held block: 255-8i descending.
    for (int i = 0; i < N; i++) begin vals[i] = W'(255 - 8 * i); set_exp(i, N - 1 - i); end
    exp_q.push_back(exp_v);
    load(1'b1);
    wait_done();
    ack(2);

    // Abort during sort phase 7: nothing pushed, so any out_valid is spurious.
    for (int i = 0; i < N; i++) vals[i] = W'(N - 1 - i);
    load(1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check_identity("abort_identity");
    reset_pulse_release();
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_valid", int'(out_valid), 0);

    // Fresh block after the abort.
    for (int i = 0; i < N; i++) begin vals[i] = W'((i * 7) % N); set_exp(i, (i * 23) % N); end
    exp_q.push_back(exp_v);
    load(1'b0);
    wait_done();
    ack(1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
